// File: rtl/sf_issue_ctrl_if.sv
// Opcode type for the simple-fixed unit plus the issue/writeback handshake bundle.
// master = instruction source and writeback consumer; slave = sf_issue_ctrl.
package sf_pkg;
    typedef enum logic [2:0] {
        ADD_WORD                = 3'd0,
        ADD_WORD_IMMEDIATE      = 3'd1,
        SUBTRACT_FROM_WORD      = 3'd2,
        AND_WORD                = 3'd3,
        XOR_WORD                = 3'd4,
        IMMEDIATE_LOAD_HALFWORD = 3'd5,
        IMMEDIATE_LOAD_WORD     = 3'd6,
        IMMEDIATE_LOAD_ADDRESS  = 3'd7
    } opcode_t;
endpackage

interface sf_issue_if #(
    parameter int REG_ADDR_WD = 7,
    parameter int REG_DATA_WD = 128
);
    import sf_pkg::*;

    logic                   issue_valid;
    logic                   issue_ready;
    opcode_t                issue_opcode;
    logic [REG_ADDR_WD-1:0] issue_rt_addr;
    logic [REG_DATA_WD-1:0] issue_ra;
    logic [REG_DATA_WD-1:0] issue_rb;
    logic [9:0]             issue_i10;
    logic [15:0]            issue_i16;
    logic [17:0]            issue_i18;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [REG_ADDR_WD-1:0] wb_rt_addr;
    logic [REG_DATA_WD-1:0] wb_data;

    modport master (
        output issue_valid, issue_opcode, issue_rt_addr, issue_ra, issue_rb,
               issue_i10, issue_i16, issue_i18, wb_ready,
        input  issue_ready, wb_valid, wb_rt_addr, wb_data
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_rt_addr, issue_ra, issue_rb,
               issue_i10, issue_i16, issue_i18, wb_ready,
        output issue_ready, wb_valid, wb_rt_addr, wb_data
    );
endinterface

// File: rtl/sf_issue_ctrl.sv
// Issue/writeback sequencer for the simple-fixed unit: S1 registers operands into the
// combinational datapath, S2..SLATENCY carry tag and result to the writeback port.
module sf_issue_ctrl
    import sf_pkg::*;
#(
    parameter  int REG_ADDR_WD = 7,
    parameter  int REG_DATA_WD = 128,
    parameter  int LATENCY     = 2,
    localparam int CNT_WD      = $clog2(LATENCY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    sf_issue_if.slave              bus,
    input  logic                   flush,
    output opcode_t                sf_opcode,
    output logic [REG_DATA_WD-1:0] sf_ra,
    output logic [REG_DATA_WD-1:0] sf_rb,
    output logic [9:0]             sf_i10,
    output logic [15:0]            sf_i16,
    output logic [17:0]            sf_i18,
    input  logic [REG_DATA_WD-1:0] sf_rt,
    input  logic [REG_ADDR_WD-1:0] hz_addr,
    output logic                   hz_hit,
    output logic [CNT_WD-1:0]      in_flight
);

    logic [LATENCY:1]                  vld_pipe;
    logic [LATENCY:1]                  drain;
    logic [LATENCY:1]                  can_load;
    logic [LATENCY:1][REG_ADDR_WD-1:0] rt_pipe;
    logic [LATENCY:2][REG_DATA_WD-1:0] res_pipe;
    logic                              accept;

    // Drain ripples back from the writeback port so a full stage can load
    // in the same cycle its occupant moves on (bubble collapse).
    always_comb begin
        drain             = '0;
        can_load          = '0;
        drain[LATENCY]    = vld_pipe[LATENCY] && bus.wb_ready;
        for (int k = LATENCY; k >= 2; k--) begin
            can_load[k]  = !vld_pipe[k] || drain[k];
            drain[k-1]   = vld_pipe[k-1] && can_load[k];
        end
        can_load[1] = !vld_pipe[1] || drain[1];
    end

    assign bus.issue_ready = rst && !flush && can_load[1];
    assign accept          = bus.issue_valid && bus.issue_ready;

    assign bus.wb_valid   = vld_pipe[LATENCY];
    assign bus.wb_rt_addr = rt_pipe[LATENCY];
    assign bus.wb_data    = res_pipe[LATENCY];

    always_comb begin
        hz_hit = 1'b0;
        for (int k = 1; k <= LATENCY; k++)
            if (vld_pipe[k] && (rt_pipe[k] == hz_addr)) hz_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            rt_pipe   <= '0;
            res_pipe  <= '0;
            in_flight <= '0;
            sf_opcode <= opcode_t'(3'd0);
            sf_ra     <= '0;
            sf_rb     <= '0;
            sf_i10    <= '0;
            sf_i16    <= '0;
            sf_i18    <= '0;
        end else begin
            if (accept) begin
                rt_pipe[1] <= bus.issue_rt_addr;
                sf_opcode  <= bus.issue_opcode;
                sf_ra      <= bus.issue_ra;
                sf_rb      <= bus.issue_rb;
                sf_i10     <= bus.issue_i10;
                sf_i16     <= bus.issue_i16;
                sf_i18     <= bus.issue_i18;
            end
            // Flush only kills valid bits; payload registers are left as they are.
            if (!flush && drain[1]) res_pipe[2] <= sf_rt;
            for (int k = 2; k <= LATENCY; k++)
                if (!flush && drain[k-1]) rt_pipe[k] <= rt_pipe[k-1];
            for (int k = 3; k <= LATENCY; k++)
                if (!flush && drain[k-1]) res_pipe[k] <= res_pipe[k-1];

            if (flush) begin
                vld_pipe  <= '0;
                in_flight <= '0;
            end else begin
                vld_pipe[1] <= accept || (vld_pipe[1] && !drain[1]);
                for (int k = 2; k <= LATENCY; k++)
                    vld_pipe[k] <= drain[k-1] || (vld_pipe[k] && !drain[k]);
                case ({accept, drain[LATENCY]})
                    2'b10:   in_flight <= in_flight + CNT_WD'(1);
                    2'b01:   in_flight <= in_flight - CNT_WD'(1);
                    default: in_flight <= in_flight;
                endcase
            end
        end
    end

endmodule

// File: doc/sf_issue_ctrl.md
# sf_issue_ctrl

Issue/writeback sequencer for the SPU-Lite simple-fixed unit in the even pipe. Accepts decoded simple-fixed instructions over a valid/ready handshake and registers their operands into the combinational `simple_fixed` datapath. Captures the result, carries the destination register tag through a LATENCY-deep pipeline with bubble collapse and writeback backpressure, and delivers results to the register-file writeback port. Also provides flush and an in-flight destination hazard lookup for the issue logic.

## Interface
- REG_ADDR_WD, 7, register address width
- REG_DATA_WD, 128, register data width
- LATENCY, 2, cycles from accepted issue to earliest wb_valid; legal range 2..8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction present
- issue_ready  out  1  controller accepts this cycle
- issue_opcode  in  Opcodes  decoded opcode
- issue_rt_addr  in  REG_ADDR_WD  destination register
- issue_ra, issue_rb  in  REG_DATA_WD  source operands
- issue_i10 / issue_i16 / issue_i18  in  10/16/18  immediates
- flush  in  1  kill all in-flight instructions
- sf_opcode  out  Opcodes  to unit
- sf_ra, sf_rb  out  REG_DATA_WD  to unit
- sf_i10 / sf_i16 / sf_i18  out  10/16/18  to unit
- sf_rt  in  REG_DATA_WD  unit result, combinational from sf_* outputs
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_rt_addr  out  REG_ADDR_WD  destination register
- wb_data  out  REG_DATA_WD  result
- hz_addr  in  REG_ADDR_WD  hazard query register
- hz_hit  out  1  some valid in-flight instruction targets hz_addr
- in_flight  out  $clog2(LATENCY+1)  count of valid stages

## Operation
- Pipeline of LATENCY stages S1..SLATENCY, each holding a valid bit and rt_addr.
- S1 also holds opcode, ra, rb, i10, i16, i18, and drives sf_* directly from these registers.
- S2..SLATENCY hold a REG_DATA_WD result. sf_rt is captured when S1 moves into S2.
- wb_* are driven from SLATENCY.
- Stage advance:
  - SLATENCY drains when wb_valid && wb_ready.
  - Sk may load when it is empty or drains in the same cycle (bubble collapse).
  - A stage that neither drains nor loads holds its contents.
- issue_ready = rst && !flush && S1 may load. Accept occurs when issue_valid && issue_ready.
- sf_* outputs keep their last registered values while S1 is empty. No operand gating.
- Opcode is not checked. The decoder routes only simple-fixed opcodes here.
- flush (synchronous):
  - All valid bits clear at the next edge; data registers unchanged.
  - No accept occurs in a flush cycle.
  - A wb handshake in the same cycle still completes, since the consumer has already sampled it.
- in_flight is a registered count of valid stages:
  - +1 on accept, -1 on wb handshake, unchanged when both occur.
  - Becomes 0 on flush.
  - Never exceeds LATENCY.
- hz_hit is combinational: OR over valid stages of (rt_addr == hz_addr). It is 0 when all stages are empty.

## Timing
- Async reset, while rst is low:
  - All valid bits 0, in_flight 0.
  - wb_valid 0, wb_rt_addr 0, wb_data 0.
  - sf_* and stage data 0; sf_opcode is the Opcodes value of encoding 0.
  - issue_ready 0, hz_hit 0.
- Reset asserted mid-operation discards all in-flight instructions immediately. No writeback appears after release.
- First accept is possible in the first cycle with rst high.
- Latency: accept at edge N makes wb_valid high after edge N+LATENCY-1, i.e. visible in cycle N+LATENCY-1, when no stall occurs.
- Throughput: 1 instruction per cycle with wb_ready held high.
- wb_valid stays high with wb_rt_addr and wb_data stable until the handshake (no retraction).
- Full pipe with wb_ready low: issue_ready is 0. A wb_ready rise allows a same-cycle accept.
- The captured result reflects S1 operands of the cycle S1 advances. S1 holds while stalled, so sf_rt is stable.

## Test plan
- IMMEDIATE_LOAD_HALFWORD, i16=0x0017, rt=5, LATENCY=2, wb_ready=1 -> one cycle later wb_valid=1, wb_rt_addr=5, wb_data=0x0017 replicated 8x; in_flight goes 1 then 0.
- Back-to-back issues of i16=1,2,3,4 (rt=1..4) -> results in order on consecutive cycles, issue_ready constantly 1.
- wb_ready=0 with 3 issues, LATENCY=2 -> 2 accepted, third sees issue_ready=0, in_flight=2, wb_data held. Raise wb_ready -> third accepted in the same cycle, all 3 delivered in order.
- Bubble collapse: issue rt=1, idle cycle, issue rt=2 with wb_ready=0 -> both accepted, in_flight=2.
- Flush with 2 in flight and issue_valid=1 -> no accept, in_flight=0, wb_valid=0 next cycle, hz_hit=0 for both addresses.
- hz_addr=9 with rt=9 in S1 -> hz_hit=1 until its writeback handshake; rst pulsed low mid-flight -> wb_valid=0, issue_ready=0 immediately.
